// File: rtl/lms_tap_scheduler.sv
// Control/state block for a time-multiplexed LMS adaptive FIR driving one shared external MAC.
// Build option: define LMS_COEF_SAT_EN to saturate (rather than wrap) the coefficient update.
module lms_tap_scheduler #(
  parameter int NTAPS    = 8,
  parameter int DW       = 16,
  parameter int ACCW     = 35,
  parameter int FRAC     = 15,
  parameter int MU_SHIFT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [DW-1:0]             i_in_sample,
  input  logic [DW-1:0]             i_in_desired,
  input  logic                      i_adapt_en,
  input  logic                      i_coef_wr,
  input  logic [$clog2(NTAPS)-1:0]  i_coef_idx,
  input  logic [DW-1:0]             i_coef_wdata,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [ACCW-1:0]           o_out_y,
  output logic [DW-1:0]             o_out_err,
  output logic                      o_mac_en,
  output logic                      o_mac_clr,
  output logic [DW-1:0]             o_mac_a,
  output logic [DW-1:0]             o_mac_b,
  input  logic [ACCW-1:0]           i_mac_acc
);
  localparam int IW = $clog2(NTAPS);
  localparam int SH = FRAC + MU_SHIFT;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIR, S_FWAIT, S_ERR, S_UPD, S_OUT} state_t;
  state_t r_state, w_next;

  logic [NTAPS-1:0][DW-1:0] r_x, r_coef;
  logic [IW:0]              r_cnt;
  logic [DW-1:0]            r_xin, r_d, r_err, r_mac_a, r_mac_b;
  logic                     r_adapt;
  logic [ACCW-1:0]          r_y;

  logic [IW-1:0]            w_k, w_wb;
  logic                     w_fir_last, w_upd_issue, w_upd_last;
  logic signed [ACCW-1:0]   w_yq_full, w_dfull;
  logic [DW-1:0]            w_yq, w_delta, w_cnew;
  logic [DW:0]              w_sum;
  logic                     w_unused;

  assign w_k         = r_cnt[IW-1:0];
  assign w_wb        = w_k - 1'b1;   // wraps to NTAPS-1 on the final write-back cycle
  assign w_fir_last  = (r_cnt == (IW+1)'(NTAPS-1));
  assign w_upd_issue = (r_state == S_UPD) && !r_cnt[IW];
  assign w_upd_last  = r_cnt[IW];

  assign w_yq_full = $signed(r_y) >>> FRAC;
  assign w_yq      = w_yq_full[DW-1:0];
  assign w_dfull   = $signed(i_mac_acc) >>> SH;
  assign w_sum     = {r_coef[w_wb][DW-1], r_coef[w_wb]} + {w_delta[DW-1], w_delta};

`ifdef LMS_COEF_SAT_EN
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  logic w_dfits;
  assign w_dfits = (&w_dfull[ACCW-1:DW-1]) | ~(|w_dfull[ACCW-1:DW-1]);
  always_comb begin
    w_delta = w_dfull[DW-1:0];
    if (!w_dfits) w_delta = w_dfull[ACCW-1] ? SMIN : SMAX;
    w_cnew = w_sum[DW-1:0];
    if (w_sum[DW] != w_sum[DW-1]) w_cnew = w_sum[DW] ? SMIN : SMAX;
  end
`else
  assign w_delta = w_dfull[DW-1:0];
  assign w_cnew  = w_sum[DW-1:0];
`endif

  assign w_unused = ^{w_yq_full, w_dfull, w_sum};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid) w_next = S_LOAD;
      S_LOAD:  w_next = S_FIR;
      S_FIR:   if (w_fir_last) w_next = S_FWAIT;
      S_FWAIT: w_next = S_ERR;
      S_ERR:   w_next = r_adapt ? S_UPD : S_OUT;
      S_UPD:   if (w_upd_last) w_next = S_OUT;
      S_OUT:   if (i_out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // MAC operands hold their last issued values while idle
  always_comb begin
    o_mac_en  = 1'b0;
    o_mac_clr = 1'b0;
    o_mac_a   = r_mac_a;
    o_mac_b   = r_mac_b;
    if (r_state == S_FIR) begin
      o_mac_en  = 1'b1;
      o_mac_clr = (r_cnt == '0);
      o_mac_a   = r_coef[w_k];
      o_mac_b   = r_x[w_k];
    end else if (w_upd_issue) begin
      o_mac_en  = 1'b1;
      o_mac_clr = 1'b1;
      o_mac_a   = r_err;
      o_mac_b   = r_x[w_k];
    end
  end

  assign o_in_ready  = rst_n && (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_OUT);
  assign o_out_y     = r_y;
  assign o_out_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_coef  <= '0;
      r_xin   <= '0;
      r_d     <= '0;
      r_err   <= '0;
      r_adapt <= 1'b0;
      r_y     <= '0;
      r_mac_a <= '0;
      r_mac_b <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= ((w_next == r_state) && (r_state == S_FIR || r_state == S_UPD)) ?
                 r_cnt + 1'b1 : '0;
      if (o_mac_en) begin
        r_mac_a <= o_mac_a;
        r_mac_b <= o_mac_b;
      end
      case (r_state)
        S_IDLE: begin
          if (i_coef_wr) r_coef[i_coef_idx] <= i_coef_wdata;
          if (i_in_valid) begin
            r_xin   <= i_in_sample;
            r_d     <= i_in_desired;
            r_adapt <= i_adapt_en;
          end
        end
        S_LOAD:  r_x <= {r_x[NTAPS-2:0], r_xin};
        S_FWAIT: r_y <= i_mac_acc;
        S_ERR:   r_err <= r_d - w_yq;
        // write-back trails issue by one cycle (MAC result visible next cycle)
        S_UPD:   if (r_cnt != '0) r_coef[w_wb] <= w_cnew;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lms_tap_scheduler.sv
// Self-checking bench for lms_tap_scheduler: MAC model plus an arithmetic LMS reference model.
module tb_lms_tap_scheduler;
  localparam int N = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 0, adapt_en = 0, coef_wr = 0, out_ready = 0;
  logic [15:0] in_sample = 0, in_desired = 0, coef_wdata = 0;
  logic [2:0]  coef_idx = 0;
  logic        in_ready, out_valid, mac_en, mac_clr;
  logic [34:0] out_y;
  logic [15:0] out_err, mac_a, mac_b;
  logic [34:0] mac_acc = '0;

  lms_tap_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_sample(in_sample), .i_in_desired(in_desired), .i_adapt_en(adapt_en),
    .i_coef_wr(coef_wr), .i_coef_idx(coef_idx), .i_coef_wdata(coef_wdata),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_y(out_y), .o_out_err(out_err),
    .o_mac_en(mac_en), .o_mac_clr(mac_clr), .o_mac_a(mac_a), .o_mac_b(mac_b),
    .i_mac_acc(mac_acc)
  );

  // External MAC: issue in cycle t, accumulator visible in t+1
  logic signed [34:0] ea, eb;
  assign ea = {{19{mac_a[15]}}, mac_a};
  assign eb = {{19{mac_b[15]}}, mac_b};
  int mac_cnt = 0;
  always @(posedge clk) begin
    if (mac_en) begin
      mac_acc <= (mac_clr ? 35'd0 : mac_acc) + 35'(ea * eb);
      mac_cnt <= mac_cnt + 1;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic over the delay line and coefficient file
  logic signed [15:0] m_x [N];
  logic signed [15:0] m_c [N];
  logic [34:0] exp_y;
  logic [15:0] exp_err;

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin m_x[i] = 0; m_c[i] = 0; end
  endfunction

  function automatic void model_step(input logic [15:0] xs, input logic [15:0] ds, input logic ad);
    longint acc, p, dl, s;
    logic [15:0] yq;
    for (int i = N-1; i > 0; i--) m_x[i] = m_x[i-1];
    m_x[0] = $signed(xs);
    acc = 0;
    for (int k = 0; k < N; k++) acc += longint'(m_c[k]) * longint'(m_x[k]);
    exp_y   = acc[34:0];
    yq      = 16'(acc >>> 15);
    exp_err = ds - yq;
    if (ad) begin
      for (int k = 0; k < N; k++) begin
        p  = longint'($signed(exp_err)) * longint'(m_x[k]);
        dl = p >>> 19;
`ifdef LMS_COEF_SAT_EN
        if (dl > 32767) dl = 32767;
        if (dl < -32768) dl = -32768;
        s = longint'(m_c[k]) + dl;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`else
        s = longint'(m_c[k]) + longint'($signed(16'(dl)));
`endif
        m_c[k] = 16'(s);
      end
    end
  endfunction

  task automatic do_reset(input string tag);
    #2 rst_n = 0;
    in_valid = 0; coef_wr = 0; out_ready = 0;
    #1;
    chk({tag, " rst in_ready"}, in_ready, 0);
    chk({tag, " rst out_valid"}, out_valid, 0);
    chk({tag, " rst mac_en"}, mac_en, 0);
    chk({tag, " rst mac_clr"}, mac_clr, 0);
    chk({tag, " rst mac_ab"}, {mac_a, mac_b}, 0);
    chk({tag, " rst out_y"}, out_y, 0);
    chk({tag, " rst out_err"}, out_err, 0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    #1 chk({tag, " first idle in_ready"}, in_ready, 1);
  endtask

  task automatic write_coef(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clk);
    coef_wr = 1; coef_idx = idx; coef_wdata = val;
    m_c[idx] = $signed(val);
    @(negedge clk);
    coef_wr = 0;
  endtask

  task automatic run_sample(input string tag, input logic [15:0] xs, input logic [15:0] ds,
                            input logic ad, input int hold,
                            input logic wr, input logic [2:0] widx, input logic [15:0] wdat);
    int lat, m0;
    logic [34:0] hy;
    logic [15:0] he;
    @(negedge clk);
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1; in_sample = xs; in_desired = ds; adapt_en = ad;
    coef_wr = wr; coef_idx = widx; coef_wdata = wdat;
    if (wr) m_c[widx] = $signed(wdat);
    model_step(xs, ds, ad);
    m0 = mac_cnt;
    @(posedge clk); lat = 1;
    @(negedge clk);
    in_valid = 0; in_sample = 16'($urandom); in_desired = 16'($urandom); adapt_en = 1'($urandom);
    coef_wr = 1; coef_idx = 3'($urandom); coef_wdata = 16'($urandom);
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
      coef_idx = 3'($urandom); coef_wdata = 16'($urandom);
    end
    chk({tag, " latency"}, lat, ad ? 2*N+5 : N+4);
    chk({tag, " mac_en cycles"}, mac_cnt - m0, ad ? 2*N : N);
    chk({tag, " out_y"}, out_y, exp_y);
    chk({tag, " out_err"}, out_err, exp_err);
    hy = out_y; he = out_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      coef_idx = 3'($urandom); coef_wdata = 16'($urandom);
      chk({tag, " hold valid"}, out_valid, 1);
      chk({tag, " hold in_ready"}, in_ready, 0);
      chk({tag, " hold y/err"}, {out_y, out_err}, {hy, he});
    end
    coef_wr = 0; out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    chk({tag, " accepted valid"}, out_valid, 0);
    chk({tag, " accepted in_ready"}, in_ready, 1);
  endtask

  initial begin
    model_clear();
    // power-on reset, then a mid-update reset with nonzero coefficients
    do_reset("por");
    write_coef(3'd0, 16'h1234);
    write_coef(3'd1, 16'hC000);
    @(negedge clk);
    in_valid = 1; in_sample = 16'h3000; in_desired = 16'h5000; adapt_en = 1;
    @(negedge clk); in_valid = 0;
    repeat (15) @(posedge clk);
    do_reset("mid-upd");
    run_sample("reset-sample", 16'h1000, 16'h0800, 0, 0, 0, 0, 0);
    chk("reset-sample literal", {out_y, out_err}, {35'd0, 16'h0800});

    // static filter
    write_coef(3'd0, 16'h4000);
    run_sample("static", 16'h2000, 16'h0000, 0, 0, 0, 0, 0);
    chk("static literal", {out_y, out_err}, {35'h0_0800_0000, 16'hF000});

    // adaptation from zero coefficients, observed through a follow-up sample
    do_reset("adapt");
    run_sample("adapt1", 16'h4000, 16'h4000, 1, 0, 0, 0, 0);
    chk("adapt1 err literal", out_err, 16'h4000);
    run_sample("adapt2", 16'h4000, 16'h0000, 0, 0, 0, 0, 0);

    // backpressure
    run_sample("backpressure", 16'h1357, 16'h2468, 1, 5, 0, 0, 0);
    run_sample("after-bp", 16'h7000, 16'h0100, 0, 0, 0, 0, 0);

    // coefficient write coinciding with the input handshake
    run_sample("wr+valid", 16'h2000, 16'h0000, 0, 0, 1, 3'd0, 16'h2000);

    // delay line
    do_reset("dline");
    write_coef(3'd7, 16'h7FFF);
    for (int i = 1; i <= 9; i++) run_sample("dline", 16'(i), 16'h0000, 0, 0, 0, 0, 0);
    chk("dline 9th literal", out_y, 35'h0_0000_FFFE);

    // coefficient overflow on update
    do_reset("sat");
    write_coef(3'd0, 16'h7F00);
    run_sample("sat1", 16'h4000, 16'h7F80, 1, 0, 0, 0, 0);
    run_sample("sat2", 16'h4000, 16'h0000, 0, 0, 0, 0, 0);
`ifdef LMS_COEF_SAT_EN
    chk("sat2 literal", out_y, 35'h0_1FFF_C000);
`else
    chk("sat2 literal", out_y, 35'h7_E040_0000);
`endif

    // randomized traffic
    do_reset("rand");
    for (int n = 0; n < 40; n++) begin
      logic wr;
      wr = ($urandom_range(0, 3) == 0);
      run_sample("rand", 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3),
                 wr, 3'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
